// File: rtl/stdp_weight_updater.sv
// -----------------------------------------------------------------------------
// stdp_weight_updater
// Read-modify-write engine for the synapse weight table. It takes one STDP
// update request at a time, reads the stored weight, applies a saturated
// potentiation or depression step and writes the result back.
//
// Ports
//   clk                : system clock, all logic on rising edge
//   rst                : asynchronous active-low reset
//   kill               : synchronous abort, drops the in-flight request
//   req_valid/ready    : request handshake (ready only while idle)
//   req_neuron_number  : target synapse index
//   req_potentiate     : 1 = add step, 0 = subtract step
//   req_dt             : absolute spike-time difference
//   syn_neuron_number  : index driven to the synapse table
//   syn_r_en/syn_w_en  : read / write strobes (never together)
//   syn_weight_wr      : weight written to the table
//   syn_weight_rd      : weight returned one cycle after syn_r_en
//   done               : one-cycle completion pulse (written or skipped)
//   upd_count          : number of completed writes, wraps
// -----------------------------------------------------------------------------
module stdp_weight_updater #(
  parameter logic [7:0] WMAX     = 8'd255,
  parameter logic [7:0] WMIN     = 8'd0,
  parameter logic [7:0] STEP_MAX = 8'd16,
  parameter int         WINDOW   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_neuron_number,
  input  logic        req_potentiate,
  input  logic [3:0]  req_dt,
  output logic [7:0]  syn_neuron_number,
  output logic        syn_r_en,
  output logic        syn_w_en,
  output logic [7:0]  syn_weight_wr,
  input  logic [7:0]  syn_weight_rd,
  output logic        done,
  output logic [15:0] upd_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        pot_q, pot_d;
  logic [3:0]  dt_q, dt_d;
  logic [7:0]  w_old_q, w_old_d;
  logic [7:0]  syn_nn_q, syn_nn_d;
  logic        r_en_q, r_en_d;
  logic        w_en_q, w_en_d;
  logic [7:0]  wr_q, wr_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;

  logic [7:0]  step_s;
  logic [8:0]  sum_s;
  logic [8:0]  floor_s;
  logic [7:0]  w_new_s;

  // Step size from the latched dt; outside the window the step is zero.
  always_comb begin
    if (32'(dt_q) < WINDOW) begin
      step_s = STEP_MAX >> dt_q;
    end else begin
      step_s = 8'd0;
    end
  end

  // Saturating update evaluated in 9 bits so overflow/underflow is visible.
  always_comb begin
    sum_s   = {1'b0, w_old_q} + {1'b0, step_s};
    floor_s = {1'b0, WMIN} + {1'b0, step_s};
    if (pot_q) begin
      if (sum_s > {1'b0, WMAX}) begin
        w_new_s = WMAX;
      end else begin
        w_new_s = sum_s[7:0];
      end
    end else begin
      if ({1'b0, w_old_q} < floor_s) begin
        w_new_s = WMIN;
      end else begin
        w_new_s = w_old_q - step_s;
      end
    end
  end

  // Next-state and next-output logic; strobes and done default low.
  always_comb begin
    state_d  = state_q;
    pot_d    = pot_q;
    dt_d     = dt_q;
    w_old_d  = w_old_q;
    syn_nn_d = syn_nn_q;
    r_en_d   = 1'b0;
    w_en_d   = 1'b0;
    wr_d     = wr_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        // Outputs are registered, so the read strobe is raised on the accept edge.
        if (req_valid && !kill) begin
          pot_d    = req_potentiate;
          dt_d     = req_dt;
          syn_nn_d = req_neuron_number;
          r_en_d   = 1'b1;
          state_d  = S_READ;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        w_old_d = syn_weight_rd;
        // step depends only on dt, so a skip can be signalled one cycle early.
        if (step_s == 8'd0) begin
          done_d = 1'b1;
        end else begin
          done_d = 1'b0;
        end
        state_d = S_CALC;
      end
      S_CALC: begin
        if (step_s == 8'd0) begin
          state_d = S_IDLE;
        end else begin
          wr_d    = w_new_s;
          w_en_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every transition. A write already on the bus in WRITE
    // was committed (with its done and count) on the previous edge.
    if (kill) begin
      state_d = S_IDLE;
      r_en_d  = 1'b0;
      w_en_d  = 1'b0;
      wr_d    = wr_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pot_q    <= 1'b0;
      dt_q     <= 4'd0;
      w_old_q  <= 8'd0;
      syn_nn_q <= 8'd0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      wr_q     <= 8'd0;
      done_q   <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      pot_q    <= pot_d;
      dt_q     <= dt_d;
      w_old_q  <= w_old_d;
      syn_nn_q <= syn_nn_d;
      r_en_q   <= r_en_d;
      w_en_q   <= w_en_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready         = (state_q == S_IDLE);
  assign syn_neuron_number = syn_nn_q;
  assign syn_r_en          = r_en_q;
  assign syn_w_en          = w_en_q;
  assign syn_weight_wr     = wr_q;
  assign done              = done_q;
  assign upd_count         = cnt_q;

endmodule
